// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU op sequencer and the 3-bit ALU datapath.
package alu_seq_pkg;

   localparam int unsigned OPW_DEF = 3;
   localparam int unsigned DW_DEF  = 3;
   localparam int unsigned RW_DEF  = 6;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      HOLD  = 2'd2,
      DONE  = 2'd3
   } seq_state_t;

   // ALU control codes, shared with the ALU itself
   localparam logic [OPW_DEF-1:0] ALU_ADD = 3'd0;
   localparam logic [OPW_DEF-1:0] ALU_SUB = 3'd1;
   localparam logic [OPW_DEF-1:0] ALU_MUL = 3'd2;
   localparam logic [OPW_DEF-1:0] ALU_AND = 3'd3;
   localparam logic [OPW_DEF-1:0] ALU_OR  = 3'd4;
   localparam logic [OPW_DEF-1:0] ALU_XOR = 3'd5;
   localparam logic [OPW_DEF-1:0] ALU_NOT = 3'd6;
   localparam logic [OPW_DEF-1:0] ALU_SHL = 3'd7;

endpackage

// File: rtl/alu_seq_opq.sv
// Op-program store: DEPTH x OPW register array, append-only with clear and indexed read.
module alu_seq_opq
   import alu_seq_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned OPW   = OPW_DEF
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       clear,
   input  logic                       wr_en,
   input  logic [OPW-1:0]             wr_op,
   input  logic [$clog2(DEPTH)-1:0]   rd_idx,
   output logic [OPW-1:0]             rd_op,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full
);

   localparam int unsigned IW = $clog2(DEPTH);
   localparam int unsigned CW = IW + 1;

   logic [OPW-1:0] mem [DEPTH];
   logic [CW-1:0]  cnt_q;

   assign full  = (cnt_q == CW'(DEPTH));
   assign count = cnt_q;
   assign rd_op = mem[rd_idx];

   // The count doubles as the write pointer: entries are only ever appended.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (clear) begin
         cnt_q <= '0;
      end else if (wr_en && !full) begin
         mem[cnt_q[IW-1:0]] <= wr_op;
         cnt_q              <= cnt_q + CW'(1);
      end
   end

endmodule

// File: rtl/alu_op_sequencer.sv
// Steps a short program of ALU codes through the ALU, holding each for a dwell time.
// Optional SEQ_LOOP_EN: repeat the program while loop is high at the end of a pass.
module alu_op_sequencer
   import alu_seq_pkg::*;
#(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned OPW     = OPW_DEF,
   parameter int unsigned DW      = DW_DEF,
   parameter int unsigned RW      = RW_DEF,
   parameter int unsigned DWELL_W = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     ena,
   input  logic                     opnd_load,
   input  logic [DW-1:0]            opnd_a,
   input  logic [DW-1:0]            opnd_b,
   input  logic                     push_valid,
   input  logic [OPW-1:0]           push_op,
   output logic                     push_ready,
   input  logic                     clear,
   input  logic                     start,
   input  logic [DWELL_W-1:0]       dwell,
   input  logic                     loop,
   output logic [DW-1:0]            alu_a,
   output logic [DW-1:0]            alu_b,
   output logic [OPW-1:0]           alu_ctrl,
   input  logic [RW-1:0]            alu_result,
   output logic [RW-1:0]            result,
   output logic                     result_valid,
   output logic                     busy,
   output logic                     done,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned IW = $clog2(DEPTH);
   localparam int unsigned CW = IW + 1;

   seq_state_t         state_q, state_d;
   logic [IW-1:0]      idx_q, idx_d;
   logic [DWELL_W-1:0] cnt_q, cnt_d;
   logic [OPW-1:0]     ctrl_q, ctrl_d;
   logic [RW-1:0]      result_q, result_d;
   logic               rv_q, rv_d;
   logic               done_q, done_d;
   logic [DW-1:0]      a_q, b_q;

   logic               q_wr, q_clr, q_full, last_op;
   logic [OPW-1:0]     rd_op;
   logic [CW-1:0]      q_count;
   logic [DWELL_W-1:0] dwell_ld;

   assign push_ready = (state_q == IDLE) && !q_full && !clear;
   assign q_wr       = ena && push_valid && push_ready;
   assign q_clr      = ena && clear && (state_q == IDLE);

   alu_seq_opq #(
      .DEPTH (DEPTH),
      .OPW   (OPW)
   ) u_opq (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (q_clr),
      .wr_en  (q_wr),
      .wr_op  (push_op),
      .rd_idx (idx_q),
      .rd_op  (rd_op),
      .count  (q_count),
      .full   (q_full)
   );

   // A dwell of 0 behaves as 1, so the hold counter preloads max(dwell,1)-1.
   assign dwell_ld = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
   assign last_op  = ({1'b0, idx_q} == (q_count - CW'(1)));

`ifndef SEQ_LOOP_EN
   logic loop_unused;
   assign loop_unused = loop;
`endif

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      ctrl_d   = ctrl_q;
      result_d = result_q;
      rv_d     = 1'b0;
      done_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start && (q_count != '0)) state_d = ISSUE;
         end
         ISSUE: begin
            ctrl_d  = rd_op;
            cnt_d   = dwell_ld;
            state_d = HOLD;
         end
         HOLD: begin
            if (cnt_q == '0) begin
               result_d = alu_result;
               rv_d     = 1'b1;
               if (last_op) begin
`ifdef SEQ_LOOP_EN
                  if (loop) begin
                     idx_d   = '0;
                     state_d = ISSUE;
                  end else begin
                     state_d = DONE;
                  end
`else
                  state_d = DONE;
`endif
               end else begin
                  idx_d   = idx_q + IW'(1);
                  state_d = ISSUE;
               end
            end else begin
               cnt_d = cnt_q - DWELL_W'(1);
            end
         end
         DONE: begin
            done_d  = 1'b1;
            idx_d   = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         cnt_q    <= '0;
         ctrl_q   <= '0;
         result_q <= '0;
         rv_q     <= 1'b0;
         done_q   <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
      end else if (ena) begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         cnt_q    <= cnt_d;
         ctrl_q   <= ctrl_d;
         result_q <= result_d;
         rv_q     <= rv_d;
         done_q   <= done_d;
         if (opnd_load) begin
            a_q <= opnd_a;
            b_q <= opnd_b;
         end
      end else begin
         rv_q   <= 1'b0;
         done_q <= 1'b0;
      end
   end

   assign alu_a        = a_q;
   assign alu_b        = b_q;
   assign alu_ctrl     = ctrl_q;
   assign result       = result_q;
   assign result_valid = rv_q && ena;
   assign done         = done_q && ena;
   assign busy         = (state_q == ISSUE) || (state_q == HOLD);
   assign count        = q_count;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural ALU and a result scoreboard.
module tb_alu_op_sequencer;

   logic       clk, rst_n, ena, opnd_load, push_valid, push_ready, clear, start, loop;
   logic [2:0] opnd_a, opnd_b, push_op, alu_a, alu_b, alu_ctrl;
   logic [7:0] dwell;
   logic [5:0] alu_result, result;
   logic       result_valid, busy, done;
   logic [2:0] count;

   int passed = 0;
   int total  = 0;

   logic [5:0] sb[$];
   logic [2:0] prog[$];
   logic [2:0] opa = 3'd3;
   logic [2:0] opb = 3'd2;

   alu_op_sequencer dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ena          (ena),
      .opnd_load    (opnd_load),
      .opnd_a       (opnd_a),
      .opnd_b       (opnd_b),
      .push_valid   (push_valid),
      .push_op      (push_op),
      .push_ready   (push_ready),
      .clear        (clear),
      .start        (start),
      .dwell        (dwell),
      .loop         (loop),
      .alu_a        (alu_a),
      .alu_b        (alu_b),
      .alu_ctrl     (alu_ctrl),
      .alu_result   (alu_result),
      .result       (result),
      .result_valid (result_valid),
      .busy         (busy),
      .done         (done),
      .count        (count)
   );

   function automatic logic [5:0] alu_model(input logic [2:0] a, input logic [2:0] b,
                                            input logic [2:0] op);
      case (op)
         3'd0: alu_model = {3'b0, a} + {3'b0, b};
         3'd1: alu_model = {3'b0, a} - {3'b0, b};
         3'd2: alu_model = {3'b0, a} * {3'b0, b};
         3'd3: alu_model = {3'b0, a & b};
         3'd4: alu_model = {3'b0, a | b};
         3'd5: alu_model = {3'b0, a ^ b};
         3'd6: alu_model = {3'b0, ~a};
         default: alu_model = {3'b0, a} << b;
      endcase
   endfunction

   assign alu_result = alu_model(alu_a, alu_b, alu_ctrl);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic push(input logic [2:0] op);
      push_valid = 1'b1;
      push_op    = op;
      @(negedge clk);
      push_valid = 1'b0;
      prog.push_back(op);
   endtask

   task automatic do_clear();
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      prog.delete();
   endtask

   // Called at a negedge; k indexes the negedge after the k-th posedge following start.
   task automatic run(input int dw, input int passes, input bit poke, input bit lp);
      int  p_len = 1 + ((dw == 0) ? 1 : dw);
      int  n     = prog.size();
      int  tot   = n * p_len * passes;
      bit  seen  = 1'b0;
      for (int p = 0; p < passes; p++)
         for (int j = 0; j < n; j++) sb.push_back(alu_model(opa, opb, prog[j]));
      dwell = dw[7:0];
      loop  = lp;
      start = 1'b1;
      for (int k = 0; (k <= tot + 4) && !seen; k++) begin
         @(negedge clk);
         check("busy", busy, k < tot);
         check("result_valid", result_valid, (k > 0) && (k % p_len == 0) && (k <= tot));
         check("done", done, k == tot + 1);
         if (k >= 1 && k <= tot) check("alu_ctrl", alu_ctrl, prog[((k - 1) / p_len) % n]);
         if (result_valid) begin
            check("sb_nonempty", sb.size() > 0, 1);
            if (sb.size() > 0) check("result", result, sb.pop_front());
         end
         if (done) seen = 1'b1;
         start = poke && (k == 2);
         if (k == n * p_len) loop = 1'b0;
      end
      check("done_seen", seen, 1);
      check("sb_drained", sb.size(), 0);
      sb.delete();
   endtask

   initial begin
      rst_n = 1'b0; ena = 1'b1; opnd_load = 1'b0; opnd_a = '0; opnd_b = '0;
      push_valid = 1'b0; push_op = '0; clear = 1'b0; start = 1'b0; dwell = '0; loop = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_alu_a", alu_a, 0);
      check("rst_alu_ctrl", alu_ctrl, 0);
      check("rst_result", result, 0);
      check("rst_result_valid", result_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_count", count, 0);
      check("rst_push_ready", push_ready, 1);
      rst_n = 1'b1;
      @(negedge clk);

      // operand load
      opnd_a = opa; opnd_b = opb; opnd_load = 1'b1;
      @(negedge clk);
      opnd_load = 1'b0;
      check("alu_a", alu_a, 3);
      check("alu_b", alu_b, 2);

      // three ops, dwell 3, stray start mid-run
      push(3'd0); push(3'd1); push(3'd2);
      check("count3", count, 3);
      run(3, 1, 1'b1, 1'b0);
      check("count_kept", count, 3);

      // fill past depth
      do_clear();
      check("count_cleared", count, 0);
      push_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         push_op = i[2:0];
         #1 check("push_ready_fill", push_ready, i < 4);
         if (i < 4) prog.push_back(i[2:0]);
         @(negedge clk);
      end
      push_valid = 1'b0;
      check("count_full", count, 4);
      check("push_ready_full", push_ready, 0);
      run(1, 1, 1'b0, 1'b0);

      // clear beats a simultaneous push
      clear = 1'b1; push_valid = 1'b1; push_op = 3'd5;
      #1 check("push_ready_clear", push_ready, 0);
      @(negedge clk);
      clear = 1'b0; push_valid = 1'b0;
      prog.delete();
      check("count_clear_push", count, 0);

      // start on empty program
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("empty_busy", busy, 0);
         check("empty_done", done, 0);
         @(negedge clk);
      end

      // ena low drops a push
      ena = 1'b0; push_valid = 1'b1; push_op = 3'd6;
      @(negedge clk);
      ena = 1'b1; push_valid = 1'b0;
      check("ena_low_push", count, 0);

      // dwell 0 acts as 1
      push(3'd3); push(3'd4);
      run(0, 1, 1'b0, 1'b0);

      // loop feature
      do_clear();
      push(3'd0); push(3'd1);
`ifdef SEQ_LOOP_EN
      run(2, 2, 1'b0, 1'b1);
`else
      run(2, 1, 1'b0, 1'b1);
`endif

      // reset during HOLD
      dwell = 8'd5; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      check("midrun_busy", busy, 1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("mr_busy", busy, 0);
      check("mr_count", count, 0);
      check("mr_alu_ctrl", alu_ctrl, 0);
      check("mr_result", result, 0);
      check("mr_alu_a", alu_a, 0);
      check("mr_push_ready", push_ready, 1);
      check("mr_done", done, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
